trdb_clock_gating_ctrl: RTL

Per-domain enable controller for the trace encoder's clock-gating cells. It watches activity and configuration for up to N_DOMAINS synchronous sub-blocks and drives each gating cell's `en_i`. It wakes a domain on demand, flags when the gated clock is stable, and shuts the domain down after a programmable idle hysteresis. It sits between the encoder top-level control and the array of `trdb_clock_gating` instances.

---
 rtl/trdb_clock_gating_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/trdb_clock_gating_ctrl.sv
// trdb_clock_gating_ctrl
//
// Per-domain enable controller for the trace encoder's clock-gating cells.
// Each domain runs an independent OFF -> WAKE -> ON FSM with its own counter.
// WAKE_CYCLES of WAKE elapse before the domain is declared ready. Once ON, the
// domain is gated off again after IDLE_CYCLES consecutive idle cycles.
//
// Ports:
//   clk_i      free-running ungated clock
//   rst_ni     synchronous active-low reset
//   cfg_en_i   per-domain permission to run
//   force_on_i global override: wake every domain and keep it on
//   busy_i     per-domain activity/request, level-sensitive
//   en_o       per-domain enable to the gating cell (state != OFF)
//   ready_o    per-domain clock running and stable (state == ON)
//   idle_o     all domains OFF
module trdb_clock_gating_ctrl #(
    parameter int N_DOMAINS   = 4,
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N_DOMAINS-1:0] cfg_en_i,
    input  logic                 force_on_i,
    input  logic [N_DOMAINS-1:0] busy_i,
    output logic [N_DOMAINS-1:0] en_o,
    output logic [N_DOMAINS-1:0] ready_o,
    output logic                 idle_o
);

    localparam int MAX_CYCLES = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        WAKE = 2'd1,
        ON   = 2'd2
    } state_t;

    state_t           state     [N_DOMAINS];
    state_t           state_nxt [N_DOMAINS];
    logic [CNT_W-1:0] cnt       [N_DOMAINS];
    logic [CNT_W-1:0] cnt_nxt   [N_DOMAINS];
    logic [N_DOMAINS-1:0] wreq;

    // Counter never wraps; it sticks at its maximum value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    assign wreq = {N_DOMAINS{force_on_i}} | (busy_i & cfg_en_i);

    always_comb begin
        for (int i = 0; i < N_DOMAINS; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            case (state[i])
                OFF: begin
                    if (wreq[i]) begin
                        state_nxt[i] = WAKE;
                        cnt_nxt[i]   = '0;
                    end
                end
                // WAKE ignores busy/config so the cell always gets a full
                // stabilisation window; only reset can abort it.
                WAKE: begin
                    if (cnt[i] == WAKE_LAST) begin
                        state_nxt[i] = ON;
                        cnt_nxt[i]   = '0;
                    end else begin
                        cnt_nxt[i] = sat_inc(cnt[i]);
                    end
                end
                ON: begin
                    if (force_on_i) begin
                        cnt_nxt[i] = '0;
                    end else if (!cfg_en_i[i]) begin
                        // Config revoked: drain outstanding work, then stop
                        // immediately without hysteresis.
                        cnt_nxt[i] = '0;
                        if (!busy_i[i]) begin
                            state_nxt[i] = OFF;
                        end
                    end else if (busy_i[i]) begin
                        // Checked before the timeout so a request landing on
                        // the final idle cycle keeps the domain on.
                        cnt_nxt[i] = '0;
                    end else if (cnt[i] == IDLE_LAST) begin
                        state_nxt[i] = OFF;
                        cnt_nxt[i]   = '0;
                    end else begin
                        cnt_nxt[i] = sat_inc(cnt[i]);
                    end
                end
                default: begin
                    state_nxt[i] = OFF;
                    cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < N_DOMAINS; i++) begin
            if (!rst_ni) begin
                state[i] <= OFF;
                cnt[i]   <= '0;
            end else begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
        end
    end

    // Outputs decode registered state only; no input reaches them
    // combinationally.
    always_comb begin
        idle_o = 1'b1;
        for (int i = 0; i < N_DOMAINS; i++) begin
            en_o[i]    = (state[i] != OFF);
            ready_o[i] = (state[i] == ON);
            if (state[i] != OFF) begin
                idle_o = 1'b0;
            end
        end
    end

endmodule
